ms_pwm_deadtime: RTL and testbench

//  Complementary PWM driver with programmable dead-time and fault shutdown, downstream of the 32-bit timer/PWM.

---
 rtl/ms_pwm_deadtime.sv | 160 ++++++++++++++++
 tb/tb_ms_pwm_deadtime.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ms_pwm_deadtime.sv
// Complementary half-bridge driver. Turns a single timer PWM into a
// high-side/low-side pair with independent rise/fall dead-times, a sticky
// fault shutdown and per-side output polarity.
module ms_pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            pol_h,
    input  logic            pol_l,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            in_deadtime,
    output logic            fault_flag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DT_RISE = 3'd1,
        HIGH    = 3'd2,
        DT_FALL = 3'd3,
        LOW     = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [DT_W-1:0] CNT_ZERO = '0;
    localparam logic [DT_W-1:0] CNT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_next;
    logic            raw_h;
    logic            raw_l;
    logic            flt_meta;
    logic            flt_s;

    // Two-flop synchroniser for the asynchronous fault pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_meta <= 1'b0;
            flt_s    <= 1'b0;
        end else begin
            flt_meta <= fault_in;
            flt_s    <= flt_meta;
        end
    end

    // State, dead-time counter, and the raw drives decoded from the next state so they are glitch-free flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= CNT_ZERO;
            raw_h      <= 1'b0;
            raw_l      <= 1'b0;
            fault_flag <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            raw_h      <= (state_next == HIGH);
            raw_l      <= (state_next == LOW);
            fault_flag <= (state_next == FAULT);
        end
    end

    // Next-state and counter: fault beats disable, disable beats PWM edges.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flt_s) begin
            state_next = FAULT;
            cnt_next   = CNT_ZERO;
        end else if (state == FAULT) begin
            cnt_next = CNT_ZERO;
            if (fault_clr) begin
                state_next = IDLE;
            end
        end else if (!en) begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pwm_in) begin
                        if (dt_rise == CNT_ZERO) begin
                            state_next = HIGH;
                            cnt_next   = CNT_ZERO;
                        end else begin
                            state_next = DT_RISE;
                            cnt_next   = dt_rise;
                        end
                    end else begin
                        if (dt_fall == CNT_ZERO) begin
                            state_next = LOW;
                            cnt_next   = CNT_ZERO;
                        end else begin
                            state_next = DT_FALL;
                            cnt_next   = dt_fall;
                        end
                    end
                end
                LOW: begin
                    if (pwm_in) begin
                        if (dt_rise == CNT_ZERO) begin
                            state_next = HIGH;
                        end else begin
                            state_next = DT_RISE;
                            cnt_next   = dt_rise - CNT_ONE;
                        end
                    end
                end
                HIGH: begin
                    if (!pwm_in) begin
                        if (dt_fall == CNT_ZERO) begin
                            state_next = LOW;
                        end else begin
                            state_next = DT_FALL;
                            cnt_next   = dt_fall - CNT_ONE;
                        end
                    end
                end
                DT_RISE: begin
                    if (!pwm_in) begin
                        state_next = LOW;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt == CNT_ZERO) begin
                        state_next = HIGH;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                DT_FALL: begin
                    if (pwm_in) begin
                        state_next = HIGH;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt == CNT_ZERO) begin
                        state_next = LOW;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end
            endcase
        end
    end

    assign pwm_h       = raw_h ^ pol_h;
    assign pwm_l       = raw_l ^ pol_l;
    assign in_deadtime = (state == DT_RISE) || (state == DT_FALL);

endmodule

// File: tb/tb_ms_pwm_deadtime.sv
// Bench for ms_pwm_deadtime: directed waveform checks plus a long random run
// compared every cycle against a time-based behavioural model.
module tb_ms_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] dt_rise = 8'd0;
    logic [7:0] dt_fall = 8'd0;
    logic       pol_h = 1'b0;
    logic       pol_l = 1'b0;
    logic       fault_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic       pwm_h;
    logic       pwm_l;
    logic       in_deadtime;
    logic       fault_flag;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Model: which side is driven, which side is waiting to come on and the edge it will.
    logic m_h, m_l, m_faulted, m_s1, m_s2;
    int   m_pend;     // 0 none, 1 heading high, 2 heading low
    int   m_on_edge;

    ms_pwm_deadtime #(.DT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
        .dt_rise(dt_rise), .dt_fall(dt_fall), .pol_h(pol_h), .pol_l(pol_l),
        .fault_in(fault_in), .fault_clr(fault_clr),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .in_deadtime(in_deadtime), .fault_flag(fault_flag)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b edge=%0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_l = 0; m_faulted = 0; m_s1 = 0; m_s2 = 0;
        m_pend = 0; m_on_edge = 0;
    endtask

    task automatic model_drive(input logic want_h);
        m_h = want_h;
        m_l = !want_h;
        m_pend = 0;
    endtask

    // One clock edge of the model using the inputs present at that edge.
    task automatic model_edge();
        logic fs, want_h;
        int   dt;
        fs = m_s2;
        m_s2 = m_s1;
        m_s1 = fault_in;
        edge_no++;
        if (fs) begin
            m_faulted = 1; m_h = 0; m_l = 0; m_pend = 0;
        end else if (m_faulted) begin
            if (fault_clr) m_faulted = 0;
        end else if (!en) begin
            m_h = 0; m_l = 0; m_pend = 0;
        end else begin
            want_h = pwm_in;
            dt = want_h ? int'(dt_rise) : int'(dt_fall);
            if ((want_h && m_h) || (!want_h && m_l)) begin
                // already on the requested side
            end else if (m_pend == (want_h ? 1 : 2)) begin
                if (edge_no >= m_on_edge) model_drive(want_h);
            end else if (m_pend != 0) begin
                // request reversed during dead-time: both sides already off
                model_drive(want_h);
            end else if (m_h || m_l) begin
                if (dt == 0) model_drive(want_h);
                else begin
                    m_h = 0; m_l = 0;
                    m_pend = want_h ? 1 : 2;
                    m_on_edge = edge_no + dt;
                end
            end else begin
                if (dt == 0) model_drive(want_h);
                else begin
                    m_pend = want_h ? 1 : 2;
                    m_on_edge = edge_no + dt + 1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        check_bit("pwm_h", pwm_h, m_h ^ pol_h);
        check_bit("pwm_l", pwm_l, m_l ^ pol_l);
        check_bit("in_deadtime", in_deadtime, m_pend != 0);
        check_bit("fault_flag", fault_flag, m_faulted);
        check_bit("no_overlap", (pwm_h ^ pol_h) & (pwm_l ^ pol_l), 1'b0);
    endtask

    // Drive inputs, take one edge, then compare away from the edge.
    task automatic applyStimulus(input logic e, input logic p, input logic f, input logic c);
        en = e; pwm_in = p; fault_in = f; fault_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    // Asynchronous reset between edges; outputs must go inactive without a clock.
    task automatic do_reset(input logic ph, input logic pl);
        @(negedge clk);
        pol_h = ph; pol_l = pl;
        en = 0; pwm_in = 0; fault_in = 0; fault_clr = 0;
        rst_n = 0;
        model_reset();
        #1;
        check_bit("rst_pwm_h", pwm_h, ph);
        check_bit("rst_pwm_l", pwm_l, pl);
        check_bit("rst_dt", in_deadtime, 1'b0);
        check_bit("rst_flag", fault_flag, 1'b0);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Rise/fall waveform with dt_rise=3, dt_fall=5 at the given polarity.
    task automatic run_case1(input logic ph, input logic pl);
        do_reset(ph, pl);
        dt_rise = 8'd3; dt_fall = 8'd5;
        for (int k = 0; k < 8; k++) applyStimulus(1, 0, 0, 0);
        check_bit("c1_low_l", pwm_l, 1'b1 ^ pl);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 1, 0, 0);
            check_bit("c1_rise_l", pwm_l, pl);
            check_bit("c1_rise_h", pwm_h, (k == 4) ^ ph);
        end
        for (int k = 0; k < 10; k++) applyStimulus(1, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 0, 0, 0);
            check_bit("c1_fall_h", pwm_h, ph);
            check_bit("c1_fall_l", pwm_l, (k == 6) ^ pl);
        end
    endtask

    initial begin
        logic p;
        int   fault_left;
        model_reset();

        // Case 1: basic dead-time timing, active-high outputs.
        run_case1(0, 0);

        // Async reset in the middle of HIGH.
        for (int k = 0; k < 8; k++) applyStimulus(1, 1, 0, 0);
        check_bit("pre_rst_h", pwm_h, 1'b1);
        do_reset(0, 0);

        // Case 2: zero dead-time follows pwm_in with one cycle of latency.
        dt_rise = 8'd0; dt_fall = 8'd0;
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            p = 1'($urandom_range(0, 1));
            applyStimulus(1, p, 0, 0);
            check_bit("dt0_follow_h", pwm_h, p);
            check_bit("dt0_follow_l", pwm_l, !p);
        end

        // Case 3: a pulse shorter than dt_rise is swallowed.
        do_reset(0, 0);
        dt_rise = 8'd8; dt_fall = 8'd0;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        check_bit("c3_low", pwm_l, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 0, 0);
            check_bit("c3_swallow_h", pwm_h, 1'b0);
        end
        applyStimulus(1, 0, 0, 0);
        check_bit("c3_back_l", pwm_l, 1'b1);
        check_bit("c3_back_h", pwm_h, 1'b0);

        // Case 4: fault entry, clear refused while asserted, then accepted.
        dt_rise = 8'd0;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        check_bit("c4_high", pwm_h, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, 0);
        check_bit("c4_flt_h", pwm_h, 1'b0);
        check_bit("c4_flt_l", pwm_l, 1'b0);
        check_bit("c4_flt_flag", fault_flag, 1'b1);
        applyStimulus(1, 1, 1, 1);
        check_bit("c4_clr_ignored", fault_flag, 1'b1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        check_bit("c4_hold_no_en", fault_flag, 1'b1);
        applyStimulus(1, 1, 0, 1);
        check_bit("c4_cleared", fault_flag, 1'b0);
        check_bit("c4_idle_h", pwm_h, 1'b0);
        applyStimulus(1, 1, 0, 0);
        check_bit("c4_resume_h", pwm_h, 1'b1);

        // Case 5: inverted polarity, then disable during DT_RISE.
        run_case1(1, 1);
        for (int k = 0; k < 8; k++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        check_bit("c5_in_dt", in_deadtime, 1'b1);
        applyStimulus(0, 1, 0, 0);
        check_bit("c5_en0_h", pwm_h, 1'b1);
        check_bit("c5_en0_l", pwm_l, 1'b1);
        check_bit("c5_en0_dt", in_deadtime, 1'b0);

        // Case 6: random traffic against the model.
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        p = 0;
        fault_left = 0;
        dt_rise = 8'($urandom_range(0, 15));
        dt_fall = 8'($urandom_range(0, 15));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) p = !p;
            if ($urandom_range(0, 19) == 0) dt_rise = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) dt_fall = 8'($urandom_range(0, 15));
            if (fault_left > 0) fault_left--;
            else if ($urandom_range(0, 199) == 0) fault_left = $urandom_range(1, 6);
            applyStimulus(($urandom_range(0, 49) != 0), p, (fault_left > 0),
                          ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
